// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
// Used by the schedule controller and by the round-key generator datapath.
package aes_pkg;

  localparam int KEY_W     = 128;
  localparam int AES128_NR = 10;

  typedef logic [3:0] round_idx_t;

  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_WAIT = 2'd1,
    KS_DONE = 2'd2
  } ks_state_t;

  // Round 0 (the idle value of kg_round) and unused rounds select a zero RCON byte.
  function automatic logic [7:0] rcon(input round_idx_t round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/round_key_table.sv
// Round-key storage: one synchronous write port, one registered read port.
// Out-of-range reads return zero; a same-edge write and read of one entry returns the old value.
module round_key_table
  import aes_pkg::*;
#(
  parameter int DEPTH = AES128_NR + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  round_idx_t       wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  round_idx_t       rd_addr,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the controller's ready flag qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < DEPTH) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: walks the external round-key generator through
// rounds 1..NR, waits out its S-box latency, and fills the local round-key table.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR       = AES128_NR,
  parameter int SBOX_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] cipher_key,
  output logic             busy,
  output logic             done,
  output logic             ready,
  output logic [3:0]       kg_round,
  output logic [KEY_W-1:0] kg_in_key,
  input  logic [KEY_W-1:0] kg_out_key,
  input  logic [3:0]       rd_addr,
  output logic [KEY_W-1:0] rd_key
);

  if (NR < 1 || NR > 15 || SBOX_LAT < 0 || SBOX_LAT > 15) begin : g_bad_params
    $error("key_schedule_ctrl: NR must be 1..15 and SBOX_LAT 0..15");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] LAT_RELOAD = 4'(SBOX_LAT);

  ks_state_t        state;
  logic [3:0]       cnt;
  logic             tbl_we;
  round_idx_t       tbl_waddr;
  logic [KEY_W-1:0] tbl_wdata;

  assign busy = (state != KS_IDLE);
  assign done = (state == KS_DONE);

  // Entry 0 is the cipher key itself; later entries are captured when the wait count expires.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = kg_round;
    tbl_wdata = kg_out_key;
    if (!rst) begin
      if (state == KS_IDLE && start) begin
        tbl_we    = 1'b1;
        tbl_waddr = '0;
        tbl_wdata = cipher_key;
      end else if (state == KS_WAIT && cnt == 4'd0) begin
        tbl_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= KS_IDLE;
      ready     <= 1'b0;
      kg_round  <= '0;
      kg_in_key <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        KS_IDLE: begin
          if (start) begin
            kg_in_key <= cipher_key;
            kg_round  <= 4'd1;
            cnt       <= LAT_RELOAD;
            ready     <= 1'b0;
            state     <= KS_WAIT;
          end
        end
        KS_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            kg_in_key <= kg_out_key;
            if (kg_round == LAST_ROUND) begin
              state <= KS_DONE;
            end else begin
              kg_round <= kg_round + 4'd1;
              cnt      <= LAT_RELOAD;
            end
          end
        end
        KS_DONE: begin
          ready    <= 1'b1;
          kg_round <= '0;
          state    <= KS_IDLE;
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

  round_key_table #(
    .DEPTH(NR + 1)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tbl_we),
    .wr_addr(tbl_waddr),
    .wr_data(tbl_wdata),
    .rd_addr(rd_addr),
    .rd_data(rd_key)
  );

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: two builds (SBOX_LAT 1 and 0), each driven by a
// behavioural AES-128 generator, with table contents checked against a FIPS-197 key expansion model.
module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_s   [2];
  logic [127:0] key_s     [2];
  logic [3:0]   rd_addr_s [2];

  logic         busy0, busy1, done0, done1, ready0, ready1;
  logic [3:0]   kgr0, kgr1;
  logic [127:0] kgi0, kgi1, kgo0, kgo1, rdk0, rdk1;

  int tests_run    = 0;
  int tests_failed = 0;

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p, r;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] prev, input logic [3:0] round);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [7:0]  rc;
    rc = 8'h00;
    if (round != 4'd0) begin
      rc = 8'h01;
      for (int i = 1; i < int'(round); i++) rc = gmul(rc, 8'h02);
    end
    {w0, w1, w2, w3} = prev;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] key, input int idx);
    logic [127:0] k;
    k = key;
    for (int r = 1; r <= idx; r++) k = next_key(k, 4'(r));
    return k;
  endfunction

  // Generator stand-ins: one registered (1-cycle S-box), one purely combinational.
  always_ff @(posedge clk) kgo1 <= next_key(kgi1, kgr1);
  assign kgo0 = next_key(kgi0, kgr0);

  key_schedule_ctrl #(.NR(10), .SBOX_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .cipher_key(key_s[0]),
    .busy(busy0), .done(done0), .ready(ready0), .kg_round(kgr0),
    .kg_in_key(kgi0), .kg_out_key(kgo0), .rd_addr(rd_addr_s[0]), .rd_key(rdk0)
  );

  key_schedule_ctrl #(.NR(10), .SBOX_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .cipher_key(key_s[1]),
    .busy(busy1), .done(done1), .ready(ready1), .kg_round(kgr1),
    .kg_in_key(kgi1), .kg_out_key(kgo1), .rd_addr(rd_addr_s[1]), .rd_key(rdk1)
  );

  function automatic logic get_busy(input int sel);   return (sel != 0) ? busy1  : busy0;  endfunction
  function automatic logic get_done(input int sel);   return (sel != 0) ? done1  : done0;  endfunction
  function automatic logic get_ready(input int sel);  return (sel != 0) ? ready1 : ready0; endfunction
  function automatic logic [3:0] get_round(input int sel); return (sel != 0) ? kgr1 : kgr0; endfunction
  function automatic logic [127:0] get_rdk(input int sel); return (sel != 0) ? rdk1 : rdk0; endfunction

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, optionally poke a second start at cycle inject_at, and run until one cycle past done.
  task automatic run_expansion(input int sel, input logic [127:0] key, input int inject_at,
                               input logic [127:0] key2, input int exp_cyc, input string tag);
    int busy_cyc;
    int done_at;
    bit finished;
    busy_cyc = 0;
    done_at  = 0;
    finished = 1'b0;
    start_s[sel] = 1'b1;
    key_s[sel]   = key;
    tick();
    start_s[sel] = 1'b0;
    for (int n = 1; n <= 80 && !finished; n++) begin
      if (n == inject_at) begin
        start_s[sel] = 1'b1;
        key_s[sel]   = key2;
      end else begin
        start_s[sel] = 1'b0;
      end
      if (get_busy(sel)) busy_cyc++;
      if (n == 1) check_output({tag, "_ready_drop"}, 128'(get_ready(sel)), 128'd0);
      if (get_done(sel)) begin
        done_at  = n;
        finished = 1'b1;
        check_output({tag, "_ready_in_done"}, 128'(get_ready(sel)), 128'd0);
        check_output({tag, "_round_in_done"}, 128'(get_round(sel)), 128'd10);
      end
      tick();
    end
    start_s[sel] = 1'b0;
    check_output({tag, "_done_cycle"}, 128'(done_at), 128'(exp_cyc));
    check_output({tag, "_busy_cycles"}, 128'(busy_cyc), 128'(exp_cyc));
    check_output({tag, "_ready_after"}, 128'(get_ready(sel)), 128'd1);
    check_output({tag, "_idle_after"}, 128'({get_busy(sel), get_done(sel)}), 128'd0);
    check_output({tag, "_round_idle"}, 128'(get_round(sel)), 128'd0);
  endtask

  task automatic watch_no_done(input int sel, input int cycles, input string tag);
    int pulses;
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      if (get_done(sel)) pulses++;
      tick();
    end
    check_output({tag, "_extra_done"}, 128'(pulses), 128'd0);
  endtask

  task automatic read_check(input int sel, input logic [3:0] addr, input logic [127:0] expected,
                            input string tag);
    rd_addr_s[sel] = addr;
    tick();
    check_output($sformatf("%s_rd%0d", tag, addr), get_rdk(sel), expected);
  endtask

  task automatic check_table(input int sel, input logic [127:0] key, input string tag);
    for (int a = 0; a <= 10; a++) read_check(sel, 4'(a), expand(key, a), tag);
  endtask

  task automatic apply_stimulus_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int           sel;
    int           inject;
    int           exp_cyc;
    logic [127:0] rkey;
    logic [127:0] rkey2;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i]   = 1'b0;
      key_s[i]     = '0;
      rd_addr_s[i] = '0;
    end
    tick();
    tick();
    check_output("rst_busy_done_ready", 128'({busy1, done1, ready1}), 128'd0);
    check_output("rst_kg_round", 128'(kgr1), 128'd0);
    check_output("rst_kg_in_key", kgi1, 128'd0);
    check_output("rst_rd_key", rdk1, 128'd0);
    check_output("rst_lat0_ready_round", 128'({ready0, kgr0}), 128'd0);
    rst = 1'b0;
    tick();
    check_output("idle_ready", 128'(ready1), 128'd0);
    check_output("idle_kg_round", 128'(kgr1), 128'd0);

    // FIPS key, then a back-to-back expansion started in the IDLE cycle after done.
    run_expansion(1, FIPS_KEY, 0, '0, 21, "fips");
    run_expansion(1, SEQ_KEY, 0, '0, 21, "b2b");
    read_check(1, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "b2b_vec");
    check_table(1, SEQ_KEY, "b2b_model");

    // A second start 5 cycles in must be ignored.
    run_expansion(1, FIPS_KEY, 5, SEQ_KEY, 21, "ignore");
    watch_no_done(1, 25, "ignore");
    read_check(1, 4'd0, FIPS_KEY, "ignore_vec");
    read_check(1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "ignore_vec");
    read_check(1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ignore_vec");
    check_table(1, FIPS_KEY, "ignore_model");

    // rd_key follows rd_addr with exactly one cycle of latency.
    rd_addr_s[1] = 4'd1;
    #1;
    check_output("rd_latency_hold", rdk1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    check_output("rd_latency_new", rdk1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_check(1, 4'd11, 128'd0, "oor");
    read_check(1, 4'd15, 128'd0, "oor");

    // Reset 7 cycles into an expansion.
    start_s[1] = 1'b1;
    key_s[1]   = SEQ_KEY;
    tick();
    start_s[1] = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_busy_done_ready", 128'({busy1, done1, ready1}), 128'd0);
    check_output("midrst_kg_round", 128'(kgr1), 128'd0);
    watch_no_done(1, 30, "midrst");
    check_output("midrst_ready_stays", 128'(ready1), 128'd0);
    run_expansion(1, FIPS_KEY, 0, '0, 21, "after_rst");
    read_check(1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "after_rst_vec");
    read_check(1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "after_rst_vec");

    // Combinational generator build.
    run_expansion(0, FIPS_KEY, 0, '0, 11, "lat0");
    read_check(0, 4'd0, FIPS_KEY, "lat0_vec");
    read_check(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "lat0_vec");
    check_table(0, FIPS_KEY, "lat0_model");

    // Random keys, random build, random ignored start somewhere in the busy window.
    for (int it = 0; it < 4; it++) begin
      sel     = int'($urandom_range(0, 1));
      exp_cyc = (sel != 0) ? 21 : 11;
      inject  = int'($urandom_range(2, exp_cyc));
      rkey    = {$urandom, $urandom, $urandom, $urandom};
      rkey2   = {$urandom, $urandom, $urandom, $urandom};
      run_expansion(sel, rkey, inject, rkey2, exp_cyc, $sformatf("rnd%0d", it));
      watch_no_done(sel, 3, $sformatf("rnd%0d", it));
      check_table(sel, rkey, $sformatf("rnd%0d", it));
      read_check(sel, 4'($urandom_range(11, 15)), 128'd0, $sformatf("rnd%0d_oor", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
